// File: rtl/seq_code_lock_pkg.sv
// rtl/seq_code_lock_pkg.sv - shared types, segment constants and hex decoder for seq_code_lock
// Contents:
//   state_t      lock FSM encoding (ST_ENTRY, ST_UNLOCKED, ST_LOCKOUT)
//   SEG_0..SEG_F seven-segment patterns {a..g}, bit6 = a, active-high
//   AN_MASK      constant digit enable pattern
//   hex_to_seg   4-bit value to segment pattern
package seq_code_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  localparam logic [7:0] AN_MASK = 8'b0001_0001;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_code_lock_btn_debounce.sv
// rtl/seq_code_lock_btn_debounce.sv - button synchroniser, stable-count debounce and press pulse
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-low reset
//   btn_in  in   raw asynchronous button level
//   press   out  one-cycle pulse on the debounced rising edge
module btn_debounce
  import seq_code_lock_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts how many consecutive samples have disagreed with the
  // accepted level; the level flips on the DB_CYCLES-th such sample.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/seq_code_lock.sv
// rtl/seq_code_lock.sv - two-button sequence lock with fail lockout, unlock window and 7-seg status
// Optional feature macro: SEQ_CODE_LOCK_TIMEOUT_EN (abandon a partial entry after ENTRY_TIMEOUT idle cycles)
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   b0_in    in   raw button entering a 0 bit
//   b1_in    in   raw button entering a 1 bit
//   unlock   out  high while UNLOCKED
//   lockout  out  high while LOCKOUT
//   a_to_g0  out  segments showing entered-bit count
//   a_to_g1  out  segments showing fail count
//   an       out  digit enables, constant
module seq_code_lock
  import seq_code_lock_pkg::*;
#(
  parameter int                  CODE_LEN       = 7,
  parameter logic [CODE_LEN-1:0] CODE           = 7'b0110110,
  parameter int                  DB_CYCLES      = 4,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  UNLOCK_CYCLES  = 100,
  parameter int                  LOCKOUT_CYCLES = 200,
  parameter int                  ENTRY_TIMEOUT  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b0_in,
  input  logic       b1_in,
  output logic       unlock,
  output logic       lockout,
  output logic [6:0] a_to_g0,
  output logic [6:0] a_to_g1,
  output logic [7:0] an
);

  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CODE_LEN-1:0] entry_q, entry_d;
  logic [FW-1:0]       fails_q, fails_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [6:0]          seg0_q, seg0_d;
  logic [6:0]          seg1_q, seg1_d;

  logic                p0, p1;
  logic                press_valid;
  logic [CODE_LEN-1:0] shifted;
  logic [CW-1:0]       count_inc;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db0 (.clk(clk), .reset(reset), .btn_in(b0_in), .press(p0));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db1 (.clk(clk), .reset(reset), .btn_in(b1_in), .press(p1));

  // Simultaneous presses are ambiguous and dropped entirely.
  assign press_valid = p0 ^ p1;
  assign shifted     = {entry_q[CODE_LEN-2:0], p1};
  assign count_inc   = count_q + 1'b1;

`ifdef SEQ_CODE_LOCK_TIMEOUT_EN
  localparam int IW = $clog2(ENTRY_TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = (ENTRY_TIMEOUT != 0);
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    entry_d = entry_q;
    fails_d = fails_q;
    timer_d = timer_q;
`ifdef SEQ_CODE_LOCK_TIMEOUT_EN
    idle_d  = idle_q;
`endif
    case (state_q)
      ST_ENTRY: begin
        if (press_valid) begin
`ifdef SEQ_CODE_LOCK_TIMEOUT_EN
          idle_d = IW'(ENTRY_TIMEOUT);
`endif
          if (count_inc == CW'(CODE_LEN)) begin
            // Compare includes the bit arriving this cycle.
            count_d = '0;
            entry_d = '0;
            if (shifted == CODE) begin
              state_d = ST_UNLOCKED;
              fails_d = '0;
              timer_d = TW'(UNLOCK_CYCLES - 1);
            end else begin
              fails_d = fails_q + 1'b1;
              if (fails_q + 1'b1 == FW'(MAX_FAILS)) begin
                state_d = ST_LOCKOUT;
                timer_d = TW'(LOCKOUT_CYCLES - 1);
              end
            end
          end else begin
            count_d = count_inc;
            entry_d = shifted;
          end
        end
`ifdef SEQ_CODE_LOCK_TIMEOUT_EN
        else if (count_q != '0) begin
          if (idle_q <= IW'(1)) begin
            count_d = '0;
            entry_d = '0;
          end else begin
            idle_d = idle_q - 1'b1;
          end
        end
`endif
      end
      ST_UNLOCKED: begin
        // A press here only re-locks; it is not taken as a code bit.
        if (press_valid || timer_q == '0) begin
          state_d = ST_ENTRY;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_ENTRY;
          fails_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_ENTRY;
    endcase

    // CODE_LEN <= 15 and MAX_FAILS <= 15 keep both values within one hex digit.
    seg0_d = hex_to_seg(4'(count_q));
    seg1_d = hex_to_seg(4'(fails_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ENTRY;
      count_q <= '0;
      entry_q <= '0;
      fails_q <= '0;
      timer_q <= '0;
      seg0_q  <= SEG_0;
      seg1_q  <= SEG_0;
`ifdef SEQ_CODE_LOCK_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      entry_q <= entry_d;
      fails_q <= fails_d;
      timer_q <= timer_d;
      seg0_q  <= seg0_d;
      seg1_q  <= seg1_d;
`ifdef SEQ_CODE_LOCK_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign unlock  = (state_q == ST_UNLOCKED);
  assign lockout = (state_q == ST_LOCKOUT);
  assign a_to_g0 = seg0_q;
  assign a_to_g1 = seg1_q;
  assign an      = AN_MASK;

endmodule
